// File: rtl/proc_trace_buffer_if.sv
// Commit-trace capture and val/rdy drain signals of proc_trace_buffer.
// master = processor/consumer side, slave = the buffer.
interface proc_trace_buffer_if;
    logic        trace_val;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic        deq_val;
    logic        deq_rdy;
    logic [31:0] deq_addr;
    logic [31:0] deq_data;
    logic [31:0] deq_cycle;

    modport master (
        output trace_val, trace_addr, trace_data, deq_rdy,
        input  deq_val, deq_addr, deq_data, deq_cycle
    );

    modport slave (
        input  trace_val, trace_addr, trace_data, deq_rdy,
        output deq_val, deq_addr, deq_data, deq_cycle
    );
endinterface

// File: rtl/proc_trace_buffer.sv
// Timestamped commit-trace FIFO with first-word fall-through drain and
// sticky overflow / saturating drop counter for records lost while full.
module proc_trace_buffer #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    proc_trace_buffer_if.slave       tif,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [95:0]   mem_q [DEPTH];
    logic [95:0]   mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   cyc_q, cyc_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_count_q, drop_count_d;

    logic full, empty, deq_fire, enq_fire, drop;

    always_comb begin
        full     = (count_q == FULL_CNT);
        empty    = (count_q == '0);
        deq_fire = !empty && tif.deq_rdy;
        enq_fire = tif.trace_val && (!full || deq_fire);
        drop     = tif.trace_val && full && !deq_fire;

        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        if (enq_fire) begin
            mem_d[tail_q] = {tif.trace_addr, tif.trace_data, cyc_q};
            tail_d        = tail_q + PTR_ONE;
        end
        if (deq_fire) begin
            head_d = head_q + PTR_ONE;
        end

        count_d = count_q;
        if (enq_fire && !deq_fire) begin
            count_d = count_q + CNT_ONE;
        end else if (deq_fire && !enq_fire) begin
            count_d = count_q - CNT_ONE;
        end

        cyc_d = cyc_q + 32'd1;

        // A drop in the same cycle as clear must leave overflow=1, drop_count=1.
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (clear) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_d != '1) begin
                drop_count_d = drop_count_d + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            cyc_q        <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            mem_q        <= mem_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            cyc_q        <= cyc_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign tif.deq_val   = !empty;
    assign tif.deq_addr  = mem_q[head_q][95:64];
    assign tif.deq_data  = mem_q[head_q][63:32];
    assign tif.deq_cycle = mem_q[head_q][31:0];
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign drop_count    = drop_count_q;
endmodule

// File: tb/tb_proc_trace_buffer.sv
// Bench for proc_trace_buffer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_proc_trace_buffer;
    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] stamp;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] drop_count;

    proc_trace_buffer_if bif();

    proc_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .tif        (bif),
        .clear      (clear),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    rec_t        mq[$];
    logic [31:0] m_cyc;
    logic        m_ovf;
    logic [15:0] m_drop;
    bit          chk_en = 0;
    int          n_total = 0;
    int          n_pass  = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Reference model: advances using the inputs present at the clock edge.
    task automatic model_edge();
        bit full, dfire, efire, drp;
        rec_t r;
        if (rst) begin
            mq.delete();
            m_cyc  = 0;
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            full  = (mq.size() == DEPTH);
            dfire = (mq.size() != 0) && bif.deq_rdy;
            efire = bif.trace_val && (!full || dfire);
            drp   = bif.trace_val && full && !dfire;
            if (dfire) void'(mq.pop_front());
            if (efire) begin
                r.addr  = bif.trace_addr;
                r.data  = bif.trace_data;
                r.stamp = m_cyc;
                mq.push_back(r);
            end
            if (clear) begin
                m_ovf  = 0;
                m_drop = 0;
            end
            if (drp) begin
                m_ovf = 1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
            m_cyc = m_cyc + 32'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(bit tv, logic [31:0] a, logic [31:0] d, bit rdy, bit clr, bit r);
        bif.trace_val  = tv;
        bif.trace_addr = a;
        bif.trace_data = d;
        bif.deq_rdy    = rdy;
        clear          = clr;
        rst            = r;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("deq_val", {31'd0, bif.deq_val}, {31'd0, mq.size() != 0});
            check("count", {28'd0, count}, 32'(mq.size()));
            check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            check("drop_count", {16'd0, drop_count}, {16'd0, m_drop});
            if (mq.size() != 0) begin
                check("deq_addr", bif.deq_addr, mq[0].addr);
                check("deq_data", bif.deq_data, mq[0].data);
                check("deq_cycle", bif.deq_cycle, mq[0].stamp);
            end
        end
    end

    initial begin
        m_cyc = 0; m_ovf = 0; m_drop = 0;
        set_in(0, '0, '0, 0, 0, 1);
        tick();
        tick();
        chk_en = 1;
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_deq_val", {31'd0, bif.deq_val}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_drop", {16'd0, drop_count}, 32'd0);

        // Three records with stamps 0,1,2, then drain.
        for (int i = 0; i < 3; i++) begin
            set_in(1, 32'h200 + 32'(4*i), 32'(i+1), 0, 0, 0);
            tick();
        end
        set_in(0, '0, '0, 0, 0, 0);
        check("basic_count", {28'd0, count}, 32'd3);
        check("basic_val", {31'd0, bif.deq_val}, 32'd1);
        check("basic_head_addr", bif.deq_addr, 32'h200);
        check("basic_head_data", bif.deq_data, 32'h1);
        check("basic_head_stamp", bif.deq_cycle, 32'd0);
        set_in(0, '0, '0, 1, 0, 0);
        tick();
        check("drain1_addr", bif.deq_addr, 32'h204);
        check("drain1_stamp", bif.deq_cycle, 32'd1);
        tick();
        check("drain2_addr", bif.deq_addr, 32'h208);
        check("drain2_stamp", bif.deq_cycle, 32'd2);
        tick();
        check("drain_empty", {31'd0, bif.deq_val}, 32'd0);

        // Fill to 8, then 3 drops.
        for (int i = 0; i < 11; i++) begin
            set_in(1, 32'h1000 + 32'(i), 32'(100 + i), 0, 0, 0);
            tick();
        end
        check("fill_count", {28'd0, count}, 32'd8);
        check("fill_overflow", {31'd0, overflow}, 32'd1);
        check("fill_drop", {16'd0, drop_count}, 32'd3);
        check("fill_head", bif.deq_addr, 32'h1000);

        // Full with simultaneous enqueue and dequeue.
        set_in(1, 32'hABCD, 32'h5555, 1, 0, 0);
        tick();
        check("full_swap_count", {28'd0, count}, 32'd8);
        check("full_swap_drop", {16'd0, drop_count}, 32'd3);
        check("full_swap_head", bif.deq_addr, 32'h1001);
        set_in(0, '0, '0, 1, 0, 0);
        for (int i = 0; i < 7; i++) tick();
        check("full_swap_last", bif.deq_addr, 32'hABCD);
        tick();
        check("full_swap_empty", {31'd0, bif.deq_val}, 32'd0);

        // Clear alone, then clear together with a drop.
        set_in(0, '0, '0, 0, 1, 0);
        tick();
        check("clear_ovf", {31'd0, overflow}, 32'd0);
        check("clear_drop", {16'd0, drop_count}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            set_in(1, 32'h3000 + 32'(i), 32'(i), 0, 0, 0);
            tick();
        end
        set_in(1, 32'h3FFF, 32'h0, 0, 1, 0);
        tick();
        check("clear_vs_drop_ovf", {31'd0, overflow}, 32'd1);
        check("clear_vs_drop_cnt", {16'd0, drop_count}, 32'd1);

        // Reset with 5 entries held and drop_count = 2.
        set_in(1, 32'h3FFE, 32'h0, 0, 0, 0);
        tick();
        set_in(0, '0, '0, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        check("pre_rst_count", {28'd0, count}, 32'd5);
        check("pre_rst_drop", {16'd0, drop_count}, 32'd2);
        set_in(1, 32'h7777, 32'h7777, 1, 1, 1);
        tick();
        check("mid_rst_count", {28'd0, count}, 32'd0);
        check("mid_rst_val", {31'd0, bif.deq_val}, 32'd0);
        check("mid_rst_drop", {16'd0, drop_count}, 32'd0);
        set_in(1, 32'h4000, 32'h4, 0, 0, 0);
        tick();
        check("post_rst_stamp", bif.deq_cycle, 32'd0);
        set_in(0, '0, '0, 1, 0, 0);
        tick();

        // Streaming with pointer wrap.
        for (int i = 0; i < 20; i++) begin
            set_in(1, 32'h5000 + 32'(i), 32'(i), 1, 0, 0);
            tick();
            check("stream_data", bif.deq_data, 32'(i));
            check("stream_count", {28'd0, count}, 32'd1);
        end
        set_in(0, '0, '0, 1, 0, 0);
        tick();
        check("stream_drops", {16'd0, drop_count}, 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 99) < 60), $urandom, $urandom,
                   ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 3),
                   ($urandom_range(0, 999) < 4));
            tick();
        end
        set_in(0, '0, '0, 1, 0, 0);
        for (int i = 0; i < 10; i++) tick();
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
